// File: rtl/otter_fetch_stage.sv
// Purpose : Otter RV32I instruction fetch. Owns the PC, drives the instruction memory and hands PC/IR pairs to decode.
// Latency : 1 cycle from IMEM_ADDR to DEC_IR (synchronous memory). Steady-state throughput is 1 instruction per cycle.
// Backpress: STALL holds the PC and the decode outputs, and a one-entry skid keeps the in-flight word. FLUSH kills that word and redirects the PC.
//
// Ports:
//   CLK, RST            rising-edge clock, asynchronous active-high reset
//   STALL, FLUSH        hazard unit controls (FLUSH wins over STALL)
//   PC_src              redirect select: 00 re-fetch PC, 01 JALR, 10 branch, 11 JAL
//   JALR_TGT, BRANCH_TGT, JAL_TGT   redirect targets from execute
//   IMEM_ADDR/IMEM_DATA instruction memory address out, word back one cycle later
//   DEC_PC, DEC_IR, DEC_VALID       decode-facing instruction slot
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [1:0]  PC_src,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] JAL_TGT,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] DEC_PC,
  output logic [31:0] DEC_IR,
  output logic        DEC_VALID
);

  logic [31:0] pc_q;       // address currently being requested
  logic [31:0] inf_pc;     // address whose word is on IMEM_DATA now
  logic        inf_valid;
  logic [31:0] skid_ir;    // word captured at the first edge of a stall
  logic        skid_full;

  logic [31:0] sel_tgt;
  logic [31:0] flush_pc;

  always_comb begin
    sel_tgt = pc_q;
    unique case (PC_src)
      2'b00: sel_tgt = pc_q;
      2'b01: sel_tgt = JALR_TGT;
      2'b10: sel_tgt = BRANCH_TGT;
      2'b11: sel_tgt = JAL_TGT;
      default: sel_tgt = pc_q;
    endcase
  end

  // Targets are not range checked, only word aligned.
  assign flush_pc = sel_tgt & ~32'h0000_0003;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q      <= RESET_VEC;
      inf_pc    <= 32'h0000_0000;
      inf_valid <= 1'b0;
      skid_ir   <= NOP;
      skid_full <= 1'b0;
    end else if (FLUSH) begin
      pc_q      <= flush_pc;
      inf_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (STALL) begin
      // The memory only returns inf_pc's word in the cycle right after it
      // was addressed. Later stall cycles return PC_q's word, so the first
      // word is latched once and held for the rest of the stall episode.
      if (!skid_full && inf_valid) begin
        skid_ir   <= IMEM_DATA;
        skid_full <= 1'b1;
      end
    end else begin
      inf_pc    <= pc_q;
      inf_valid <= 1'b1;
      pc_q      <= pc_q + 32'd4;
      skid_full <= 1'b0;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign DEC_PC    = inf_pc;
  assign DEC_VALID = inf_valid;
  assign DEC_IR    = !inf_valid ? NOP : (skid_full ? skid_ir : IMEM_DATA);

endmodule

// File: tb/tb_otter_fetch_stage.sv
module tb_otter_fetch_stage;
  localparam logic [31:0] RV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH;
  logic [1:0]  PC_src;
  logic [31:0] JALR_TGT, BRANCH_TGT, JAL_TGT;
  logic [31:0] IMEM_ADDR, IMEM_DATA, DEC_PC, DEC_IR;
  logic        DEC_VALID;

  int checks = 0;
  int passed = 0;

  // Reference model: next fetch address and the instruction decode should see.
  logic [31:0] m_pc, m_dec_pc;
  logic        m_valid;

  otter_fetch_stage #(.RESET_VEC(RV), .NOP(NOP)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .PC_src(PC_src),
    .JALR_TGT(JALR_TGT), .BRANCH_TGT(BRANCH_TGT), .JAL_TGT(JAL_TGT),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
    .DEC_PC(DEC_PC), .DEC_IR(DEC_IR), .DEC_VALID(DEC_VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge CLK) IMEM_DATA <= mem_word(IMEM_ADDR);

  // {IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID} the model requires.
  function automatic logic [96:0] exp_bus();
    return {m_pc, m_dec_pc, (m_valid ? mem_word(m_dec_pc) : NOP), m_valid};
  endfunction

  task automatic model_reset();
    m_pc = RV; m_dec_pc = 32'h0; m_valid = 1'b0;
  endtask

  // Apply controls, take one edge, advance the model, settle 1 time unit.
  task automatic edge_step(input logic s, input logic f, input logic [1:0] src);
    logic [31:0] t;
    STALL = s; FLUSH = f; PC_src = src;
    @(posedge CLK);
    if (f) begin
      case (src)
        2'b01:   t = JALR_TGT;
        2'b10:   t = BRANCH_TGT;
        2'b11:   t = JAL_TGT;
        default: t = m_pc;
      endcase
      m_pc = {t[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!s) begin
      m_dec_pc = m_pc;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; PC_src = 2'b00;
    JALR_TGT = 32'h0; BRANCH_TGT = 32'h0; JAL_TGT = 32'h0;
    model_reset();
    #1;
    checks++; if ({IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID} !== {RV, 32'h0, NOP, 1'b0})
      $display("FAIL reset_immediate: got %h required %h", {IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID}, {RV, 32'h0, NOP, 1'b0});
    else passed++;
    @(posedge CLK); #1;
    checks++; if ({IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID} !== exp_bus())
      $display("FAIL reset_held: got %h required %h", {IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID}, exp_bus());
    else passed++;
    RST = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] want [3] = '{32'h100, 32'h104, 32'h108};
    checks++; if (DEC_VALID !== 1'b0)
      $display("FAIL seq_first_invalid: got %b required 0", DEC_VALID);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      edge_step(1'b0, 1'b0, 2'b00);
      checks++; if ({DEC_PC, DEC_IR, DEC_VALID} !== {want[i], mem_word(want[i]), 1'b1})
        $display("FAIL seq_%0d: got %h/%h/%b required %h/%h/1", i, DEC_PC, DEC_IR, DEC_VALID, want[i], mem_word(want[i]));
      else passed++;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      edge_step(1'b1, 1'b0, 2'b00);
      checks++; if ({IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID} !== {32'h10C, 32'h108, mem_word(32'h108), 1'b1})
        $display("FAIL stall_hold_%0d: got %h/%h/%h/%b required 10c/108/%h/1", i, IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID, mem_word(32'h108));
      else passed++;
    end
    edge_step(1'b0, 1'b0, 2'b00);
    checks++; if ({DEC_PC, DEC_IR, DEC_VALID} !== {32'h10C, mem_word(32'h10C), 1'b1})
      $display("FAIL stall_release: got %h/%h/%b required 10c/%h/1", DEC_PC, DEC_IR, DEC_VALID, mem_word(32'h10C));
    else passed++;
  endtask

  task automatic test_redirect();
    BRANCH_TGT = 32'h200;
    edge_step(1'b0, 1'b1, 2'b10);
    checks++; if ({DEC_IR, DEC_VALID} !== {NOP, 1'b0})
      $display("FAIL branch_bubble: got %h/%b required %h/0", DEC_IR, DEC_VALID, NOP);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      edge_step(1'b0, 1'b0, 2'b00);
      checks++; if ({DEC_PC, DEC_IR, DEC_VALID} !== {32'h200 + 32'(4 * i), mem_word(32'h200 + 32'(4 * i)), 1'b1})
        $display("FAIL branch_target_%0d: got %h/%h/%b required %h", i, DEC_PC, DEC_IR, DEC_VALID, 32'h200 + 32'(4 * i));
      else passed++;
    end
    JALR_TGT = 32'h301;
    edge_step(1'b0, 1'b1, 2'b01);
    checks++; if (IMEM_ADDR !== 32'h300)
      $display("FAIL jalr_align: got %h required 00000300", IMEM_ADDR);
    else passed++;
    edge_step(1'b0, 1'b0, 2'b00);
    checks++; if ({DEC_PC, DEC_IR, DEC_VALID} !== {32'h300, mem_word(32'h300), 1'b1})
      $display("FAIL jalr_target: got %h/%h/%b required 300", DEC_PC, DEC_IR, DEC_VALID);
    else passed++;
  endtask

  task automatic test_stall_flush();
    edge_step(1'b1, 1'b0, 2'b00);  // fills the skid with the word at 0x300
    JAL_TGT = 32'h400;
    edge_step(1'b1, 1'b1, 2'b11);
    checks++; if ({DEC_IR, DEC_VALID} !== {NOP, 1'b0})
      $display("FAIL stall_flush_bubble: got %h/%b required %h/0", DEC_IR, DEC_VALID, NOP);
    else passed++;
    edge_step(1'b0, 1'b0, 2'b00);
    checks++; if ({DEC_PC, DEC_IR, DEC_VALID} !== {32'h400, mem_word(32'h400), 1'b1})
      $display("FAIL stall_flush_target: got %h/%h/%b required 400/%h/1", DEC_PC, DEC_IR, DEC_VALID, mem_word(32'h400));
    else passed++;
  endtask

  task automatic test_back_to_back();
    BRANCH_TGT = 32'h500; JAL_TGT = 32'h600;
    edge_step(1'b0, 1'b1, 2'b10);
    edge_step(1'b0, 1'b1, 2'b11);
    checks++; if ({IMEM_ADDR, DEC_VALID} !== {32'h600, 1'b0})
      $display("FAIL b2b_flush: got %h/%b required 600/0", IMEM_ADDR, DEC_VALID);
    else passed++;
    edge_step(1'b0, 1'b0, 2'b00);
    checks++; if ({DEC_PC, DEC_IR, DEC_VALID} !== {32'h600, mem_word(32'h600), 1'b1})
      $display("FAIL b2b_target: got %h/%h/%b required 600", DEC_PC, DEC_IR, DEC_VALID);
    else passed++;
  endtask

  task automatic test_wrap();
    JALR_TGT = 32'hFFFF_FFFF;
    edge_step(1'b0, 1'b1, 2'b01);
    edge_step(1'b0, 1'b0, 2'b00);
    checks++; if ({IMEM_ADDR, DEC_PC, DEC_VALID} !== {32'h0, 32'hFFFF_FFFC, 1'b1})
      $display("FAIL wrap_addr: got %h/%h/%b required 00000000/fffffffc/1", IMEM_ADDR, DEC_PC, DEC_VALID);
    else passed++;
    edge_step(1'b0, 1'b0, 2'b00);
    checks++; if ({DEC_PC, DEC_IR} !== {32'h0, mem_word(32'h0)})
      $display("FAIL wrap_dec: got %h/%h required 0/%h", DEC_PC, DEC_IR, mem_word(32'h0));
    else passed++;
  endtask

  task automatic test_async_reset();
    edge_step(1'b1, 1'b0, 2'b00);
    edge_step(1'b1, 1'b0, 2'b00);
    #2 RST = 1'b1;
    model_reset();
    #1;
    checks++; if ({IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID} !== {RV, 32'h0, NOP, 1'b0})
      $display("FAIL async_reset: got %h required %h", {IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID}, {RV, 32'h0, NOP, 1'b0});
    else passed++;
    @(posedge CLK); #3 RST = 1'b0;
    STALL = 1'b0;
    edge_step(1'b0, 1'b0, 2'b00);
    checks++; if ({DEC_PC, DEC_IR, DEC_VALID, IMEM_ADDR} !== {RV, mem_word(RV), 1'b1, RV + 32'd4})
      $display("FAIL reset_restart: got %h/%h/%b/%h required %h", DEC_PC, DEC_IR, DEC_VALID, IMEM_ADDR, RV);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      JALR_TGT = $urandom; BRANCH_TGT = $urandom; JAL_TGT = $urandom;
      edge_step(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
      checks++; if ({IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID} !== exp_bus()) begin
        if (errs < 10)
          $display("FAIL random_%0d: got %h required %h", i, {IMEM_ADDR, DEC_PC, DEC_IR, DEC_VALID}, exp_bus());
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_flush();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
